// File: rtl/ext_slot_seq.sv
`default_nettype none
// ============================================================================
// Module      : ext_slot_seq
// Description : Bus-cycle controller for a 4-subslot expanded MSX slot.
//               Holds the secondary-slot register at FFFFh (inverted
//               readback), decodes per-page subslot selects, inserts
//               WAIT_CYCLES Z80 wait states per subslot access and routes
//               the selected subslot's BUSDIR request back to the host.
//               Optional macro EXT_SLOT_SUB_WAIT_EN lets each subslot
//               stretch the access further through its own SUB_WAITn.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_slot_seq #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [3:0] SUB_MASK    = 4'b1111
) (
    input  logic        SLT_CLOCK,
    input  logic        SLT_RESETn,
    input  logic        SLT_SLTSL,
    input  logic        SLT_RDn,
    input  logic        SLT_WEn,
    input  logic [15:0] SLT_A,
    inout  wire  [7:0]  SLT_D,
    input  logic [3:0]  SUB_BUSDIRn,
    input  logic [3:0]  SUB_WAITn,
    output logic [3:0]  SUB_SLTSLn,
    output logic        SLT_WAITn,
    output logic        SLT_BUSDIRn,
    output logic        SEQ_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REG    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam bit         c_has_wait  = (WAIT_CYCLES != 0);
    localparam logic [2:0] c_wait_load = 3'(WAIT_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_secreg;
    logic [2:0] r_wait_cnt;
    logic [2:0] w_wait_cnt_next;
    logic [1:0] r_cur_sub;
    logic [1:0] w_cur_sub_next;
    logic       w_secreg_we;

    logic [1:0] w_page;
    logic [1:0] w_sel;
    logic [1:0] w_sub;
    logic       w_is_ffff;
    logic       w_hit;
    logic       w_reg;
    logic       w_strobe;
    logic       w_in_access;
    logic       w_sub_wait_ok;
    logic       w_rd_en;

    assign w_page    = SLT_A[15:14];
    assign w_sel     = r_secreg[{w_page, 1'b0} +: 2];
    assign w_is_ffff = (SLT_A == 16'hFFFF);
    assign w_hit     = !SLT_SLTSL && !w_is_ffff;
    assign w_reg     = !SLT_SLTSL && w_is_ffff;
    assign w_strobe  = !SLT_RDn || !SLT_WEn;

    // While an access is in flight the subslot chosen at IDLE exit stays put,
    // so a secreg change only affects the next access.
    assign w_in_access = (r_state == ST_WAIT) || (r_state == ST_ACTIVE);
    assign w_sub       = w_in_access ? r_cur_sub : w_sel;

`ifdef EXT_SLOT_SUB_WAIT_EN
    assign w_sub_wait_ok = SUB_WAITn[r_cur_sub];
`else
    logic w_sub_wait_unused;
    assign w_sub_wait_unused = &SUB_WAITn;
    assign w_sub_wait_ok     = 1'b1;
`endif

    // Inverted readback on FFFFh: pull a bit low where secreg holds a 1.
    // A simultaneous write strobe makes this a write, so the bus is left to the host.
    assign w_rd_en = SLT_RESETn && w_reg && !SLT_RDn && SLT_WEn;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rdback
        assign SLT_D[gi] = (w_rd_en && r_secreg[gi]) ? 1'b0 : 1'bz;
    end

    // State, wait counter, latched subslot and secondary-slot register.
    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_cur_sub  <= 2'd0;
            r_secreg   <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_cur_sub  <= w_cur_sub_next;
            if (w_secreg_we) begin
                r_secreg <= SLT_D;
            end
        end
    end

    // Next-state logic and bus-facing outputs.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_cur_sub_next  = r_cur_sub;
        w_secreg_we     = 1'b0;
        SUB_SLTSLn      = 4'b1111;
        SLT_WAITn       = 1'b1;
        SLT_BUSDIRn     = 1'b1;
        SEQ_BUSY        = (r_state != ST_IDLE);

        unique case (r_state)
            ST_IDLE: begin
                if (w_reg && w_strobe) begin
                    w_state_next = ST_REG;
                end else if (w_hit && w_strobe && SUB_MASK[w_sel]) begin
                    w_cur_sub_next = w_sel;
                    if (c_has_wait) begin
                        w_state_next    = ST_WAIT;
                        w_wait_cnt_next = c_wait_load;
                    end else begin
                        w_state_next = ST_ACTIVE;
                    end
                end
            end
            ST_REG: begin
                w_secreg_we = w_reg && !SLT_WEn;
                if (SLT_SLTSL || !w_strobe) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                SLT_WAITn = 1'b0;
                if (SLT_SLTSL) begin
                    w_state_next    = ST_IDLE;
                    w_wait_cnt_next = 3'd0;
                end else if (r_wait_cnt == 3'd0) begin
                    if (w_sub_wait_ok) begin
                        w_state_next = ST_ACTIVE;
                    end
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 3'd1;
                end
            end
            ST_ACTIVE: begin
                if (SLT_SLTSL || !w_strobe) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

`ifdef EXT_SLOT_SUB_WAIT_EN
        if (w_in_access) begin
            SLT_WAITn = SLT_WAITn && SUB_WAITn[r_cur_sub];
        end
`endif

        if (SLT_RESETn && w_hit && SUB_MASK[w_sub]) begin
            SUB_SLTSLn[w_sub] = 1'b0;
        end

        if (w_in_access && !SLT_RDn) begin
            SLT_BUSDIRn = SUB_BUSDIRn[r_cur_sub];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_slot_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_slot_seq
// Description : Directed self-checking bench for ext_slot_seq
//               (WAIT_CYCLES = 3, all four subslots populated).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_slot_seq;

    localparam int W = 3;
`ifdef EXT_SLOT_SUB_WAIT_EN
    localparam int c_exp_subwait_lows = 5;
`else
    localparam int c_exp_subwait_lows = W;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sltsl;
    logic        rdn;
    logic        wen;
    logic [15:0] a;
    logic [3:0]  sub_busdirn;
    logic [3:0]  sub_waitn;
    logic [3:0]  sub_sltsln;
    logic        waitn;
    logic        busdirn;
    logic        busy;
    logic [7:0]  d_drv;
    logic        d_oe;
    wire  [7:0]  slt_d;

    int n_cmp = 0;
    int n_err = 0;

    assign slt_d = d_oe ? d_drv : 8'hzz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pullup
        pullup pu (slt_d[gi]);
    end

    always #5 clk = ~clk;

    ext_slot_seq #(
        .WAIT_CYCLES (W),
        .SUB_MASK    (4'b1111)
    ) dut (
        .SLT_CLOCK   (clk),
        .SLT_RESETn  (rst_n),
        .SLT_SLTSL   (sltsl),
        .SLT_RDn     (rdn),
        .SLT_WEn     (wen),
        .SLT_A       (a),
        .SLT_D       (slt_d),
        .SUB_BUSDIRn (sub_busdirn),
        .SUB_WAITn   (sub_waitn),
        .SUB_SLTSLn  (sub_sltsln),
        .SLT_WAITn   (waitn),
        .SLT_BUSDIRn (busdirn),
        .SEQ_BUSY    (busy)
    );

    task automatic bus_idle();
        sltsl = 1'b1;
        rdn   = 1'b1;
        wen   = 1'b1;
        a     = 16'h0000;
        d_oe  = 1'b0;
        d_drv = 8'h00;
    endtask

    // Host write cycle to FFFFh: one edge to enter REG, one edge that stores.
    task automatic write_reg(input logic [7:0] v);
        @(negedge clk);
        sltsl = 1'b0; a = 16'hFFFF; wen = 1'b0; d_oe = 1'b1; d_drv = v;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_idle();
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        sub_busdirn = 4'b1111;
        sub_waitn   = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (sub_sltsln !== 4'b1111) begin n_err++; $display("FAIL reset_sub_sltsln: got %b expected 1111", sub_sltsln); end
        n_cmp++; if (waitn !== 1'b1) begin n_err++; $display("FAIL reset_waitn: got %b expected 1", waitn); end
        n_cmp++; if (busdirn !== 1'b1) begin n_err++; $display("FAIL reset_busdirn: got %b expected 1", busdirn); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        sltsl = 1'b0; a = 16'hFFFF; rdn = 1'b0;
        #1;
        n_cmp++; if (slt_d !== 8'hFF) begin n_err++; $display("FAIL reset_readback: got %h expected ff", slt_d); end
        n_cmp++; if (sub_sltsln !== 4'b1111) begin n_err++; $display("FAIL reg_no_sub_sltsln: got %b expected 1111", sub_sltsln); end
        @(posedge clk); #1;
        n_cmp++; if ({busy, waitn} !== 2'b11) begin n_err++; $display("FAIL reg_enter_busy_waitn: got %b expected 11", {busy, waitn}); end
        @(posedge clk); #1;
        n_cmp++; if (waitn !== 1'b1) begin n_err++; $display("FAIL reg_no_wait: got %b expected 1", waitn); end
        @(negedge clk);
        bus_idle();
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reg_exit_busy: got %b expected 0", busy); end
    endtask

    task automatic test_secreg();
        logic [3:0] exp_tab [4];
        exp_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        write_reg(8'hE4);
        @(negedge clk);
        sltsl = 1'b0; a = 16'hFFFF; rdn = 1'b0;
        #1;
        n_cmp++; if (slt_d !== 8'h1B) begin n_err++; $display("FAIL secreg_readback: got %h expected 1b", slt_d); end
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            sltsl = 1'b0; a = 16'(p) << 14; rdn = 1'b0;
            #1;
            n_cmp++; if (sub_sltsln !== exp_tab[p]) begin n_err++; $display("FAIL page%0d_decode: got %b expected %b", p, sub_sltsln, exp_tab[p]); end
            repeat (W + 1) @(posedge clk);
            #1;
            n_cmp++; if ({busy, waitn, sub_sltsln} !== {2'b11, exp_tab[p]}) begin
                n_err++; $display("FAIL page%0d_active: got %b expected %b", p, {busy, waitn, sub_sltsln}, {2'b11, exp_tab[p]});
            end
            @(negedge clk);
            bus_idle();
            @(posedge clk);
        end
    endtask

    task automatic test_wait_count();
        int lows = 0;
        int bad  = 0;
        write_reg(8'h04);
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0;
        #1;
        n_cmp++; if (waitn !== 1'b1) begin n_err++; $display("FAIL wait_before_edge: got %b expected 1", waitn); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (waitn === 1'b0) lows++;
            if (sub_sltsln !== 4'b1101) bad++;
        end
        n_cmp++; if (lows != W) begin n_err++; $display("FAIL wait_count: got %0d expected %0d", lows, W); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wait_sub_sltsln: got %0d bad samples expected 0", bad); end
        n_cmp++; if ({busy, waitn} !== 2'b11) begin n_err++; $display("FAIL wait_then_active: got %b expected 11", {busy, waitn}); end
        bus_idle();
        @(posedge clk);
    endtask

    task automatic test_abort();
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (waitn !== 1'b0) begin n_err++; $display("FAIL abort_in_wait: got %b expected 0", waitn); end
        sltsl = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({waitn, busy, sub_sltsln} !== 6'b10_1111) begin
            n_err++; $display("FAIL abort_release: got %b expected 101111", {waitn, busy, sub_sltsln});
        end
        @(negedge clk);
        bus_idle();
        @(posedge clk);
    endtask

    task automatic test_busdir();
        sub_busdirn = 4'b1101;
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0;
        #1;
        n_cmp++; if (busdirn !== 1'b1) begin n_err++; $display("FAIL busdir_idle: got %b expected 1", busdirn); end
        @(posedge clk); #1;
        n_cmp++; if (busdirn !== 1'b0) begin n_err++; $display("FAIL busdir_sub1_read: got %b expected 0", busdirn); end
        @(negedge clk); bus_idle(); @(posedge clk);
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; wen = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busdirn !== 1'b1) begin n_err++; $display("FAIL busdir_on_write: got %b expected 1", busdirn); end
        @(negedge clk); bus_idle(); @(posedge clk);
        write_reg(8'h00);
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busdirn !== 1'b1) begin n_err++; $display("FAIL busdir_other_sub: got %b expected 1", busdirn); end
        @(negedge clk); bus_idle(); @(posedge clk);
        sub_busdirn = 4'b1110;
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busdirn !== 1'b0) begin n_err++; $display("FAIL busdir_sub0_read: got %b expected 0", busdirn); end
        @(negedge clk); bus_idle(); @(posedge clk);
        sub_busdirn = 4'b1111;
    endtask

    task automatic test_sub_wait();
        int lows = 0;
        write_reg(8'h04);
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0; sub_waitn = 4'b1101;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (waitn === 1'b0) lows++;
            if (i == 5) sub_waitn = 4'b1111;
        end
        n_cmp++; if (lows != c_exp_subwait_lows) begin n_err++; $display("FAIL sub_wait_count: got %0d expected %0d", lows, c_exp_subwait_lows); end
        bus_idle();
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        write_reg(8'hE4);
        sub_busdirn = 4'b1101;
        @(negedge clk);
        sltsl = 1'b0; a = 16'h4000; rdn = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({busy, waitn, busdirn, sub_sltsln} !== 7'b100_1101) begin
            n_err++; $display("FAIL pre_reset_wait: got %b expected 1001101", {busy, waitn, busdirn, sub_sltsln});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, waitn, busdirn, sub_sltsln} !== 7'b011_1111) begin
            n_err++; $display("FAIL async_reset_outputs: got %b expected 0111111", {busy, waitn, busdirn, sub_sltsln});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_idle();
        sub_busdirn = 4'b1111;
        @(negedge clk);
        sltsl = 1'b0; a = 16'hFFFF; rdn = 1'b0;
        #1;
        n_cmp++; if (slt_d !== 8'hFF) begin n_err++; $display("FAIL secreg_cleared: got %h expected ff", slt_d); end
        @(negedge clk);
        bus_idle();
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_secreg();
        test_wait_count();
        test_abort();
        test_busdir();
        test_sub_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ext_slot_seq.md
Name: ext_slot_seq

Overview:
- Bus-cycle controller for a 4-subslot expanded MSX slot.
- Owns the secondary-slot register at FFFFh and decodes per-page subslot selects into four one-hot SUB_SLTSLn strobes.
- Sequences each subslot access through a state machine that inserts a programmable number of Z80 wait states and arbitrates BUSDIR back to the host.
- Sits between the MSX slot edge and the four expansion connectors; replaces plain combinational subslot decode.

Parameters:
WAIT_CYCLES, 1, Z80 wait states inserted per subslot memory access (0..7; 0 = none).
SUB_MASK, 4'b1111, bit n = 1 means subslot n is populated; unpopulated subslots never get SUB_SLTSLn.

Ports:
SLT_CLOCK  input  1  Z80 clock from slot, all state changes on rising edge.
SLT_RESETn  input  1  asynchronous active-low reset.
SLT_SLTSL  input  1  primary slot select, active low.
SLT_RDn  input  1  read strobe, active low.
SLT_WEn  input  1  write strobe, active low.
SLT_A  input  16  address bus.
SLT_D  inout  8  data bus, open-drain style: drive 0 or Z only.
SUB_BUSDIRn  input  4  per-subslot BUSDIR request, active low.
SUB_WAITn  input  4  per-subslot WAIT request, active low (used only with the optional feature).
SUB_SLTSLn  output  4  per-subslot select, active low, one-hot or all 1.
SLT_WAITn  output  1  WAIT to host, active low.
SLT_BUSDIRn  output  1  BUSDIR to host, active low.
SEQ_BUSY  output  1  high whenever the FSM is not IDLE (debug/LED).

Behaviour:
- Reset is SLT_RESETn, asynchronous, active-low; the clock is SLT_CLOCK.
- Reset values: secreg=8'h00, FSM=IDLE, wait counter=0, SUB_SLTSLn=4'b1111, SLT_WAITn=1, SLT_BUSDIRn=1, SEQ_BUSY=0, SLT_D all Z.
- Reset asserted mid-access forces all of these values immediately.
- Definitions:
  - sel = secreg[2p+1:2p], where p = SLT_A[15:14].
  - hit = !SLT_SLTSL & (SLT_A != 16'hFFFF).
  - reg = !SLT_SLTSL & (SLT_A == 16'hFFFF).
  - strobe = !SLT_RDn | !SLT_WEn.
- SUB_SLTSLn[sel] = 0 combinationally whenever hit & SUB_MASK[sel]; otherwise all 1. SUB_SLTSLn is never driven during reg.
- FSM states: IDLE, REG, WAIT, ACTIVE.
  - IDLE -> REG when reg & strobe.
  - IDLE -> WAIT when hit & strobe & SUB_MASK[sel] & WAIT_CYCLES != 0. Load counter = WAIT_CYCLES-1.
  - IDLE -> ACTIVE when hit & strobe & SUB_MASK[sel] & WAIT_CYCLES == 0.
  - IDLE stays on hit to an unmasked subslot; the bus floats.
  - WAIT: SLT_WAITn = 0 (combinational from state). Counter decrements each clock; at counter==0 go to ACTIVE next edge.
  - WAIT, SLT_SLTSL high (abort) -> IDLE; SLT_WAITn releases at that edge.
  - ACTIVE: SLT_WAITn = 1. Stay while !SLT_SLTSL & strobe. -> IDLE when SLT_SLTSL high or both strobes high.
  - REG: write secreg <= SLT_D on every edge with !SLT_WEn (idempotent). -> IDLE when SLT_SLTSL high or strobes inactive.
- Exactly WAIT_CYCLES SLT_CLOCK edges with SLT_WAITn=0 per access; no wait ever on FFFFh.
- Readback: when reg & !SLT_RDn, drive SLT_D[i]=0 where ~secreg[i]==0, else Z (inverted readback, MSX convention). Combinational, no state required.
- A secreg write takes effect for sel on the next access. The current access keeps the subslot latched at IDLE exit (latch sel into cur_sub). SUB_SLTSLn uses cur_sub while in WAIT/ACTIVE.
- SLT_BUSDIRn = SUB_BUSDIRn[cur_sub] in WAIT/ACTIVE with !SLT_RDn; otherwise 1. Requests from non-selected subslots are ignored.
- Simultaneous RDn and WEn low: treated as write for REG, as an ordinary access otherwise.
- SEQ_BUSY = (state != IDLE).

Optional Feature:
- Macro EXT_SLOT_SUB_WAIT_EN.
- Defined: in WAIT and ACTIVE, SLT_WAITn = internal wait & SUB_WAITn[cur_sub]. The FSM does not leave WAIT until the counter is 0 and SUB_WAITn[cur_sub] = 1.
- Not defined: SUB_WAITn is unused and tied off internally; SLT_WAITn depends on the counter only.

Test Plan:
- Reset, then read FFFFh with SLTSL=0 -> SLT_D reads 8'hFF (secreg 00 inverted); SUB_SLTSLn=1111; no WAIT.
- Write 8'hE4 to FFFFh, then read FFFFh -> 8'h1B. Access 0000h/4000h/8000h/C000h -> SUB_SLTSLn = 1110/1101/1011/0111 respectively.
- WAIT_CYCLES=2, read 4000h with secreg=8'h04 -> SLT_WAITn low for exactly 2 rising edges, then ACTIVE; SUB_SLTSLn=1101 throughout.
- SLTSL deasserted after 1 wait cycle with WAIT_CYCLES=3 -> FSM returns to IDLE next edge; SLT_WAITn=1, SEQ_BUSY=0.
- SUB_BUSDIRn=4'b1101, read 4000h -> SLT_BUSDIRn=0. Same stimulus with secreg page1=subslot 0 -> SLT_BUSDIRn=1.
- With EXT_SLOT_SUB_WAIT_EN, SUB_WAITn[1] held low for 5 cycles -> SLT_WAITn low for 5 cycles (≥ WAIT_CYCLES). SLT_RESETn asserted mid-WAIT -> all outputs at reset values asynchronously.
